// File: rtl/host_rx_word_packer_pkg.sv
// Shared field offsets, state encoding and limits for the host receive word packer.
package host_rx_word_packer_pkg;

  localparam int SLOTS  = 16;
  localparam int BYTE_W = 8;

  localparam int WORD_W      = 134;
  localparam int WORD_HEAD   = 133;
  localparam int WORD_TAIL   = 132;
  localparam int WORD_IDX_HI = 131;
  localparam int WORD_IDX_LO = 128;

  localparam int DESC_W       = 31;
  localparam int DESC_CTRL_HI = 30;
  localparam int DESC_CTRL_LO = 12;
  localparam int DESC_LEN_HI  = 11;
  localparam int DESC_LEN_LO  = 1;
  localparam int DESC_ERR     = 0;

  localparam int MAX_LEN_DEFAULT = 1522;
  localparam logic [10:0] LEN_SAT = 11'd2047;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1
  } state_e;

endpackage

// File: rtl/host_rx_word_packer_byte_slot.sv
// 16x8 byte slot register with indexed write and whole-register clear on emit.
// ov_bytes_merged shows the slots with this cycle's write already applied.
module host_rx_byte_slot
  import host_rx_word_packer_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr,
  input  logic [3:0]   iv_idx,
  input  logic [7:0]   iv_byte,
  input  logic         i_clr,
  output logic [127:0] ov_bytes_merged
);

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      logic [BYTE_W-1:0] slot_q;
      logic [BYTE_W-1:0] slot_d;

      always_comb begin
        slot_d = slot_q;
        if (i_wr && (iv_idx == 4'(gi))) begin
          slot_d = iv_byte;
        end
      end

      // Slot 0 is the first byte of the word and lands in the top byte lane.
      assign ov_bytes_merged[127-BYTE_W*gi -: BYTE_W] = slot_d;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          slot_q <= '0;
        end else if (i_clr) begin
          slot_q <= '0;
        end else begin
          slot_q <= slot_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/host_rx_word_packer.sv
// Packs the delimited byte stream into 134-bit buffer words and emits one
// descriptor (control word, length, error) per frame.
module host_rx_word_packer
  import host_rx_word_packer_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [8:0]   iv_data,
  input  logic         i_data_wr,
  input  logic [18:0]  iv_ctrl_data,
  output logic [133:0] ov_word,
  output logic         o_word_wr,
  output logic [30:0]  ov_desc,
  output logic         o_desc_wr,
  output logic [1:0]   ov_state
);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [10:0]   len_q, len_d;
  logic [10:0]   len_inc;
  logic          head_q, head_d;
  logic [18:0]   ctrl_q, ctrl_d;
  logic [15:0]   stray_q, stray_d;
  logic [133:0]  word_q, word_d;
  logic          word_wr_q, word_wr_d;
  logic [30:0]   desc_q, desc_d;
  logic          desc_wr_q, desc_wr_d;

  logic          slot_wr;
  logic          slot_clr;
  logic [3:0]    slot_idx;
  logic [127:0]  slot_bytes;

  host_rx_byte_slot u_slot (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_wr            (slot_wr),
    .iv_idx          (slot_idx),
    .iv_byte         (iv_data[7:0]),
    .i_clr           (slot_clr),
    .ov_bytes_merged (slot_bytes)
  );

  assign len_inc = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    head_d    = head_q;
    ctrl_d    = ctrl_q;
    stray_d   = stray_q;
    word_d    = '0;
    word_wr_d = 1'b0;
    desc_d    = '0;
    desc_wr_d = 1'b0;
    slot_wr   = 1'b0;
    slot_clr  = 1'b0;
    slot_idx  = cnt_q;

    if (i_data_wr) begin
      case (state_q)
        ST_IDLE: begin
          if (iv_data[8]) begin
            ctrl_d   = iv_ctrl_data;
            slot_wr  = 1'b1;
            slot_idx = 4'd0;
            cnt_d    = 4'd1;
            len_d    = 11'd1;
            head_d   = 1'b1;
            state_d  = ST_PACK;
          end else begin
            stray_d = stray_q + 16'd1;
          end
        end
        ST_PACK: begin
          slot_wr = 1'b1;
          len_d   = len_inc;
          if (!iv_data[8]) begin
            if (cnt_q == 4'd15) begin
              word_d[WORD_HEAD]                = head_q;
              word_d[WORD_TAIL]                = 1'b0;
              word_d[WORD_IDX_HI:WORD_IDX_LO]  = 4'd15;
              word_d[127:0]                    = slot_bytes;
              word_wr_d = 1'b1;
              slot_clr  = 1'b1;
              head_d    = 1'b0;
              cnt_d     = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            // Tail byte: close the word and the frame in the same cycle.
            word_d[WORD_HEAD]                = head_q;
            word_d[WORD_TAIL]                = 1'b1;
            word_d[WORD_IDX_HI:WORD_IDX_LO]  = cnt_q;
            word_d[127:0]                    = slot_bytes;
            desc_d[DESC_CTRL_HI:DESC_CTRL_LO] = ctrl_q;
            desc_d[DESC_LEN_HI:DESC_LEN_LO]   = len_inc;
            desc_d[DESC_ERR]                  = (int'(len_inc) > MAX_LEN);
            word_wr_d = 1'b1;
            desc_wr_d = 1'b1;
            slot_clr  = 1'b1;
            head_d    = 1'b0;
            cnt_d     = 4'd0;
            len_d     = 11'd0;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      head_q    <= 1'b0;
      ctrl_q    <= '0;
      stray_q   <= '0;
      word_q    <= '0;
      word_wr_q <= 1'b0;
      desc_q    <= '0;
      desc_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      head_q    <= head_d;
      ctrl_q    <= ctrl_d;
      stray_q   <= stray_d;
      word_q    <= word_d;
      word_wr_q <= word_wr_d;
      desc_q    <= desc_d;
      desc_wr_q <= desc_wr_d;
    end
  end

  assign ov_word   = word_q;
  assign o_word_wr = word_wr_q;
  assign ov_desc   = desc_q;
  assign o_desc_wr = desc_wr_q;
  assign ov_state  = state_q;

endmodule
